// File: rtl/boot_loader.sv
// ROM download bridge: queues ioctl bytes and writes them to SDRAM,
// one byte per ce_ref slot pair, with a busy hold-off after draining.
module boot_loader #(
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ce_ref,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t         state_q, state_d;
    logic [30:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [HW-1:0]  hold;
    logic           dl_q;
    logic [10:0]    page_sel;
    logic [8:0]     page;
    logic           rom_dl, push_req, push, overflow;
    logic           full, empty, pop, load;

    assign rom_dl   = ioctl_download && (ioctl_index == 8'd0);
    assign page_sel = ioctl_addr[24:14];
    assign push_req = rom_dl && ioctl_wr && (page_sel <= 11'd2);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = push_req && !full;
    assign overflow = push_req && full;

    always_comb begin
        case (page_sel)
            11'd1:   page = 9'h100;
            11'd2:   page = 9'h107;
            default: page = 9'h000;
        endcase
    end

    // Storage has no reset; flushing is done through the pointers.
    always_ff @(posedge clk_sys) begin
        if (push)
            fifo_mem[wr_ptr] <= {page, ioctl_addr[13:0], ioctl_dout};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ce_ref && !empty) state_d = WRITE;
            WRITE:   if (ce_ref)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_we = (state_q == WRITE);
        pop    = (state_q == WRITE) && ce_ref;
        load   = (state_q == IDLE) && ce_ref && !empty;
    end

    // Head is latched at write start so the bus stays stable in WRITE.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (load) begin
            {mem_addr, mem_din} <= fifo_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            hold <= '0;
        else if (rom_dl || !empty || state_q == WRITE)
            hold <= HW'(HOLD_CYCLES);
        else if (hold != '0)
            hold <= hold - 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q <= 1'b0;
            err  <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (overflow)
                err <= 1'b1;
            else if (rom_dl && !dl_q)
                err <= 1'b0;
        end
    end

    assign busy = rom_dl || !empty || (state_q == WRITE) || (hold != '0);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: address mapping, drain pacing,
// overflow, hold-off timing, reset abort and foreign-index downloads.
module tb_boot_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ce_ref;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [7:0]  mem_din;
    logic        busy;
    logic        err;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int we_cycles = 0;
    logic we_prev = 1'b0;
    logic [30:0] wq [$];

    boot_loader #(.FIFO_DEPTH(8), .HOLD_CYCLES(16)) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ce_ref(ce_ref),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_din(mem_din),
        .busy(busy),
        .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (mem_we)
            we_cycles++;
        if (mem_we && !we_prev)
            wq.push_back({mem_addr, mem_din});
        we_prev = mem_we;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
    endtask

    task automatic ce_pulse();
        ce_ref = 1'b1;
        step();
        ce_ref = 1'b0;
    endtask

    task automatic periods(input int n);
        for (int i = 0; i < n; i++) begin
            ce_pulse();
            repeat (15) step();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        logic gap;
        logic seen;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ce_ref         = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_mem_we",   {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {9'd0, mem_addr}, 32'd0);
        check("rst_mem_din",  {24'd0, mem_din}, 32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check("rst_err",      {31'd0, err}, 32'd0);

        // single byte, page 1
        ioctl_download = 1'b1;
        step();
        wr_byte(25'h4003, 8'hA5);
        check("dl_busy", {31'd0, busy}, 32'd1);
        ioctl_download = 1'b0;
        step();
        wq.delete();
        we_cycles = 0;
        ce_pulse();
        repeat (15) step();
        check("w1_we",   {31'd0, mem_we}, 32'd1);
        check("w1_addr", {9'd0, mem_addr}, 32'h400003);
        check("w1_din",  {24'd0, mem_din}, 32'hA5);
        ce_pulse();
        check("w1_we_drop", {31'd0, mem_we}, 32'd0);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check("hold_len", n, 32'd16);
        check("w1_count",  wq.size(), 32'd1);
        check("w1_cycles", we_cycles, 32'd16);

        // restart during hold countdown
        ioctl_download = 1'b1;
        wr_byte(25'h0010, 8'h5A);
        ioctl_download = 1'b0;
        step();
        ce_pulse();
        repeat (15) step();
        ce_pulse();
        gap = 1'b0;
        repeat (11) begin
            if (!busy) gap = 1'b1;
            step();
        end
        ioctl_download = 1'b1;
        repeat (4) begin
            if (!busy) gap = 1'b1;
            step();
        end
        ioctl_download = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check("restart_gap", {31'd0, gap}, 32'd0);
        check("restart_hold", n, 32'd16);

        // page 2 maps high, page 3 discarded
        wq.delete();
        ioctl_download = 1'b1;
        step();
        wr_byte(25'h8000, 8'h11);
        wr_byte(25'hC000, 8'h22);
        ioctl_download = 1'b0;
        periods(4);
        check("pg_count", wq.size(), 32'd1);
        if (wq.size() > 0)
            check("pg2_entry", {1'b0, wq[0]}, {1'b0, 23'h41C000, 8'h11});
        check("pg3_err", {31'd0, err}, 32'd0);
        wait_idle();

        // overflow with ce_ref idle
        wq.delete();
        ioctl_download = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            ioctl_addr = 25'(i);
            ioctl_dout = 8'(8'h30 + i);
            ioctl_wr   = 1'b1;
            step();
        end
        ioctl_wr = 1'b0;
        check("ovf_err", {31'd0, err}, 32'd1);
        ioctl_download = 1'b0;
        step();
        check("ovf_no_we", {31'd0, mem_we}, 32'd0);
        periods(18);
        check("ovf_count", wq.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < wq.size())
                check($sformatf("ovf_entry%0d", i), {1'b0, wq[i]},
                      {1'b0, 23'(i), 8'(8'h30 + i)});
        end
        check("ovf_err_sticky", {31'd0, err}, 32'd1);
        wait_idle();
        ioctl_download = 1'b1;
        step();
        check("err_clr", {31'd0, err}, 32'd0);
        ioctl_download = 1'b0;
        wait_idle();

        // reset mid-write
        ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++)
            wr_byte(25'(25'h100 + i), 8'(8'h70 + i));
        ioctl_download = 1'b0;
        ce_pulse();
        repeat (3) step();
        check("pre_rst_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        step();
        check("abort_we",   {31'd0, mem_we}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_addr", {9'd0, mem_addr}, 32'd0);
        reset = 1'b0;
        wq.delete();
        periods(4);
        check("abort_writes", wq.size(), 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);

        // foreign index ignored
        seen = 1'b0;
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_byte(25'(i), 8'(8'h90 + i));
            seen = seen | busy;
            ce_pulse();
            seen = seen | busy;
            repeat (3) begin
                step();
                seen = seen | busy;
            end
        end
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        repeat (4) begin
            step();
            seen = seen | busy;
        end
        check("idx1_writes", wq.size(), 32'd0);
        check("idx1_busy",   {31'd0, seen}, 32'd0);
        check("idx1_err",    {31'd0, err}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
